// File: rtl/fetch_unit.sv
//==============================================================================
// Module   : fetch_unit
// Purpose  : Multi-cycle instruction fetch stage. It owns the program counter,
//            fetches one word per instruction over a req/valid handshake, holds
//            the word for the decoder, and selects the next PC from the
//            decoder's control outputs and the ALU zero flag.
//            The loop is FETCH -> WAIT -> ISSUE and is not pipelined.
// Ports    : clk, rst                    clock, synchronous active-high reset
//            imem_addr/imem_req          fetch address and request strobe
//            imem_rdata/imem_valid       memory response
//            instr/instr_valid           word held for the decoder
//            advance                     decoder done; next-PC inputs valid
//            pcSrcCtrl, bneCtrl, zero,
//            jAddr, imm, jr_target       next-PC selection inputs
//            pc, pc_plus4                current PC and PC+4 (link value)
//            fetch_err                   one-cycle fetch timeout pulse
// Options  : FETCH_TIMEOUT_EN  - when defined, a fetch with no response for
//            TIMEOUT WAIT cycles is re-issued and fetch_err pulses.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        advance,
  input  logic [1:0]  pcSrcCtrl,
  input  logic        bneCtrl,
  input  logic        zero,
  input  logic [25:0] jAddr,
  input  logic [31:0] imm,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  localparam logic [1:0] SRC_SEQ    = 2'd0;
  localparam logic [1:0] SRC_JUMP   = 2'd1;
  localparam logic [1:0] SRC_JR     = 2'd2;
  localparam logic [1:0] SRC_BRANCH = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] branch_tgt_w;
  logic        taken_w;
  logic [31:0] next_pc_w;
  logic        timeout_hit_w;

  // imm[31:30] fall off the word-offset shift; JR targets are forced aligned.
  logic w_unused_bits;
  assign w_unused_bits = ^{imm[31:30], jr_target[1:0]};

  //--------------------------------------------------------------------------
  // Next-PC selection
  //--------------------------------------------------------------------------
  assign pc_plus4_w   = pc_q + 32'd4;
  assign branch_tgt_w = pc_plus4_w + {imm[29:0], 2'b00};
  assign taken_w      = zero ^ bneCtrl;

  always_comb begin
    next_pc_w = pc_plus4_w;
    case (pcSrcCtrl)
      SRC_SEQ:    next_pc_w = pc_plus4_w;
      SRC_JUMP:   next_pc_w = {pc_plus4_w[31:28], jAddr, 2'b00};
      SRC_JR:     next_pc_w = {jr_target[31:2], 2'b00};
      SRC_BRANCH: next_pc_w = taken_w ? branch_tgt_w : pc_plus4_w;
      default:    next_pc_w = pc_plus4_w;
    endcase
  end

  //--------------------------------------------------------------------------
  // Optional fetch timeout
  //--------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fetch_err_q;

  // A response in the cycle the count would reach TIMEOUT takes priority.
  assign timeout_hit_w = (state_q == S_WAIT) && !imem_valid &&
                         (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_FETCH) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT && !imem_valid) begin
      cnt_d = timeout_hit_w ? '0 : cnt_q + 1'b1;
    end
  end

  // Registered so the pulse coincides with the re-issued request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      fetch_err_q <= timeout_hit_w;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign timeout_hit_w    = 1'b0;
  assign fetch_err        = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // Fetch/issue control
  //--------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      S_FETCH: begin
        // Any response in this cycle belongs to no request and is dropped.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_ISSUE;
        end else if (timeout_hit_w) begin
          state_d = S_FETCH;
        end
      end
      S_ISSUE: begin
        if (advance) begin
          pc_d          = next_pc_w;
          instr_valid_d = 1'b0;
          state_d       = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Request is suppressed while reset is held so no fetch escapes reset.
  assign imem_req    = (state_q == S_FETCH) && !rst;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//==============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A driver plays instruction
//            memory and decoder; expected fetch addresses and instruction
//            words are queued by the driver and checked by a monitor.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic        instr_valid;
  logic        advance;
  logic [1:0]  pcSrcCtrl;
  logic        bneCtrl;
  logic        zero;
  logic [25:0] jAddr;
  logic [31:0] imm;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr(instr), .instr_valid(instr_valid),
    .advance(advance), .pcSrcCtrl(pcSrcCtrl), .bneCtrl(bneCtrl), .zero(zero),
    .jAddr(jAddr), .imm(imm), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] model_pc;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next-PC rule in plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [1:0] src,
                                           input logic bne, input logic z,
                                           input logic [25:0] ja, input logic [31:0] im,
                                           input logic [31:0] jr);
    logic [31:0] seq;
    seq = p + 32'd4;
    case (src)
      2'd0:    return seq;
      2'd1:    return (seq & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
      2'd2:    return jr & 32'hFFFF_FFFC;
      default: return (z != bne) ? seq + im * 32'd4 : seq;
    endcase
  endfunction

  //--------------------------------------------------------------------------
  // Monitor
  //--------------------------------------------------------------------------
  logic [31:0] cur_pc    = RESET_PC;
  logic [31:0] cur_instr = 32'h0;
  logic        prev_iv   = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (imem_req) begin
        if (exp_addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected fetch: got addr %h expected no request at %0t", imem_addr, $time);
        end else begin
          cur_pc = exp_addr_q.pop_front();
          chk("fetch addr", imem_addr, cur_pc);
          chk("pc at fetch", pc, cur_pc);
          chk("pc_plus4", pc_plus4, cur_pc + 32'd4);
        end
      end
      if (instr_valid && !prev_iv) begin
        if (exp_instr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected instr: got %h expected no word at %0t", instr, $time);
        end else begin
          cur_instr = exp_instr_q.pop_front();
          chk("instr", instr, cur_instr);
        end
      end else if (instr_valid) begin
        chk("instr hold", instr, cur_instr);
        chk("pc hold", pc, cur_pc);
      end
`ifndef FETCH_TIMEOUT_EN
      chk("fetch_err tied", {31'd0, fetch_err}, 32'd0);
`endif
      prev_iv = instr_valid;
    end
  end

  //--------------------------------------------------------------------------
  // Driver: one full FETCH/WAIT/ISSUE round
  //--------------------------------------------------------------------------
  task automatic do_instr(input logic [1:0] src, input logic bne, input logic z,
                          input logic [25:0] ja, input logic [31:0] im,
                          input logic [31:0] jr, input int lat, input int hold,
                          input bit stray);
    int n;
    logic [31:0] w;
    n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!imem_req) begin
      n_vec++; n_err++;
      $display("FAIL fetch wait: got no imem_req expected request within 50 cycles");
      return;
    end
    // FETCH cycle: stray response and spurious advance must be ignored.
    imem_valid = stray ? 1'b1 : 1'($urandom);
    imem_rdata = $urandom;
    advance    = 1'($urandom);
    pcSrcCtrl  = 2'($urandom);
    @(posedge clk); #1;
    chk("valid ignored in fetch", {31'd0, instr_valid}, 32'd0);
    for (int i = 1; i < lat; i++) begin
      imem_valid = 1'b0;
      advance    = 1'($urandom);
      pcSrcCtrl  = 2'($urandom);
      jr_target  = $urandom;
`ifdef FETCH_TIMEOUT_EN
      chk("fetch_err in wait", {31'd0, fetch_err}, 32'd0);
`endif
      @(posedge clk); #1;
    end
    w = $urandom;
    imem_valid = 1'b1;
    imem_rdata = w;
    exp_instr_q.push_back(w);
    @(posedge clk); #1;
    // ISSUE: hold the decoder off, with junk responses on the bus.
    advance = 1'b0;
    for (int h = 0; h < hold; h++) begin
      imem_valid = 1'($urandom);
      imem_rdata = $urandom;
      @(posedge clk); #1;
    end
`ifdef FETCH_TIMEOUT_EN
    chk("fetch_err in issue", {31'd0, fetch_err}, 32'd0);
`endif
    imem_valid = 1'($urandom);
    advance    = 1'b1;
    pcSrcCtrl  = src;
    bneCtrl    = bne;
    zero       = z;
    jAddr      = ja;
    imm        = im;
    jr_target  = jr;
    model_pc   = ref_next(model_pc, src, bne, z, ja, im, jr);
    exp_addr_q.push_back(model_pc);
    @(posedge clk); #1;
    advance    = 1'b0;
    imem_valid = 1'b0;
  endtask

  task automatic rand_instr();
    logic [31:0] im;
    im = ($urandom_range(0, 1) == 1) ? 32'($signed(8'($urandom))) : $urandom;
    do_instr(2'($urandom), 1'($urandom), 1'($urandom), 26'($urandom), im, $urandom,
             $urandom_range(1, 3), $urandom_range(0, 2), 1'b0);
  endtask

  // Reset asserted while waiting for memory; the stale response is abandoned.
  task automatic reset_in_wait();
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1; n++;
    end
    imem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid reset pc", pc, RESET_PC);
    chk("mid reset instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid reset req low", {31'd0, imem_req}, 32'd0);
    model_pc = RESET_PC;
    exp_addr_q.push_back(RESET_PC);
    rst = 1'b0;
    #1;
    chk("post reset req", {31'd0, imem_req}, 32'd1);
    chk("post reset addr", imem_addr, RESET_PC);
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic timeout_case();
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1; n++;
    end
    imem_valid = 1'b0;
    advance    = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("no early fetch_err", {31'd0, fetch_err}, 32'd0);
      @(posedge clk); #1;
    end
    exp_addr_q.push_back(model_pc);
    @(posedge clk); #1;
    chk("fetch_err pulse", {31'd0, fetch_err}, 32'd1);
    chk("refetch req", {31'd0, imem_req}, 32'd1);
    chk("refetch addr", imem_addr, model_pc);
  endtask
`endif

  //--------------------------------------------------------------------------
  // Stimulus
  //--------------------------------------------------------------------------
  initial begin
    rst = 1'b1; imem_rdata = '0; imem_valid = 1'b0; advance = 1'b0;
    pcSrcCtrl = '0; bneCtrl = 1'b0; zero = 1'b0; jAddr = '0; imm = '0; jr_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req", {31'd0, imem_req}, 32'd0);
    chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset instr", instr, 32'h0);
    chk("reset fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("reset pc", pc, RESET_PC);
    model_pc = RESET_PC;
    exp_addr_q.push_back(RESET_PC);
    mon_en = 1'b1;
    rst    = 1'b0;
    #1;

    // Sequential, jump, branch sense, JR alignment, wrap-around.
    do_instr(2'd0, 1'b0, 1'b0, 26'd0,      32'd0,          32'd0,          1, 0, 1'b0);
    do_instr(2'd0, 1'b0, 1'b0, 26'd0,      32'd0,          32'd0,          1, 0, 1'b0);
    do_instr(2'd2, 1'b0, 1'b0, 26'd0,      32'd0,          32'h1000_0040,  1, 5, 1'b0);
    do_instr(2'd1, 1'b0, 1'b0, 26'd231435, 32'd0,          32'd0,          2, 0, 1'b0);
    do_instr(2'd2, 1'b0, 1'b0, 26'd0,      32'd0,          32'h0000_0100,  1, 0, 1'b0);
    do_instr(2'd3, 1'b0, 1'b1, 26'd0,      32'hFFFF_FFFE,  32'd0,          1, 0, 1'b0);
    do_instr(2'd2, 1'b0, 1'b0, 26'd0,      32'd0,          32'h0000_0100,  1, 0, 1'b0);
    do_instr(2'd3, 1'b1, 1'b1, 26'd0,      32'hFFFF_FFFE,  32'd0,          3, 0, 1'b0);
    do_instr(2'd2, 1'b0, 1'b0, 26'd0,      32'd0,          32'h0000_0100,  1, 0, 1'b0);
    do_instr(2'd3, 1'b1, 1'b0, 26'd0,      32'hFFFF_FFFE,  32'd0,          1, 1, 1'b0);
    do_instr(2'd2, 1'b0, 1'b0, 26'd0,      32'd0,          32'h0000_0207,  1, 0, 1'b0);
    do_instr(2'd2, 1'b0, 1'b0, 26'd0,      32'd0,          32'hFFFF_FFFE,  1, 0, 1'b0);
    do_instr(2'd0, 1'b0, 1'b0, 26'd0,      32'd0,          32'd0,          1, 0, 1'b0);

    for (int k = 0; k < 60; k++) rand_instr();

    reset_in_wait();
    do_instr(2'd0, 1'b0, 1'b0, 26'd0, 32'd0, 32'd0, 1, 0, 1'b1);
    for (int k = 0; k < 10; k++) rand_instr();

`ifdef FETCH_TIMEOUT_EN
    timeout_case();
    do_instr(2'd0, 1'b0, 1'b0, 26'd0, 32'd0, 32'd0, 1, 0, 1'b0);
    do_instr(2'd0, 1'b0, 1'b0, 26'd0, 32'd0, 32'd0, 4, 0, 1'b0);
`endif

    // Let the final request be observed.
    for (int n = 0; n < 20 && exp_addr_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("pending fetches", 32'(exp_addr_q.size()), 32'd0);
    chk("pending words", 32'(exp_instr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
